// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

   // Fetch FSM states: IDLE only for the cycle after reset, then REQ/WAIT/HOLD loop
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   // Next-PC selection driven by the FSM into the PC register
   typedef enum logic [1:0] {
      PC_KEEP  = 2'd0,
      PC_INC   = 2'd1,
      PC_REDIR = 2'd2
   } pc_sel_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold / +4 / aligned-redirect next-PC mux.
// Latency: new PC visible the cycle after sel is applied.
// Backpressure: none; the FSM holds the PC by selecting PC_KEEP.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  pc_sel_t         sel,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc
);

   // Redirect targets are forced to a 4-byte boundary; the add wraps at XLEN bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else begin
         case (sel)
            PC_INC:   pc <= pc + XLEN'(PC_INCR);
            PC_REDIR: pc <= redirect_pc & ~XLEN'(3);
            default:  pc <= pc;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request at a time, instruction+PC presented to decode.
// Latency: REQ -> WAIT -> HOLD, out_valid the cycle after imem_rsp_valid; 3 cycles minimum per instruction.
// Backpressure: HOLD keeps outputs stable and issues no request until out_ready or a redirect.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instruction
);

   fetch_state_t    state;
   logic            drop;
   logic [XLEN-1:0] pc;
   pc_sel_t         pc_sel;

   fetch_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel         (pc_sel),
      .redirect_pc (redirect_pc),
      .pc          (pc)
   );

   // The request address is the PC register itself, so it only moves on a redirect or +4
   assign imem_req_addr = pc;

   // Redirect wins over the +4 that a completed decode transfer would cause
   always_comb begin
      pc_sel = PC_KEEP;
      if (redirect_valid) begin
         pc_sel = PC_REDIR;
      end else if (state == HOLD && out_ready) begin
         pc_sel = PC_INC;
      end
   end

   // Fetch FSM with registered handshake outputs; drop marks an in-flight response as stale
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         drop            <= 1'b0;
         imem_req_valid  <= 1'b0;
         out_valid       <= 1'b0;
         out_pc          <= RESET_PC;
         out_instruction <= ILEN'(NOP_INSTR);
      end else begin
         case (state)
            IDLE: begin
               state          <= REQ;
               imem_req_valid <= 1'b1;
            end
            REQ: begin
               if (imem_req_ready) begin
                  state          <= WAIT;
                  imem_req_valid <= 1'b0;
                  drop           <= redirect_valid;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop || redirect_valid) begin
                     drop           <= 1'b0;
                     state          <= REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     out_instruction <= imem_rsp_data;
                     out_pc          <= pc;
                     out_valid       <= 1'b1;
                     state           <= HOLD;
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect_valid || out_ready) begin
                  out_valid      <= 1'b0;
                  state          <= REQ;
                  imem_req_valid <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
